nf_i_fu_pipe: RTL and testbench
===============================

# nf_i_fu_pipe

Pipelined instruction fetch unit for the nanoFOX core. It holds the fetch PC and drives the instruction-memory request/ack handshake. It delivers fetched instructions and their PC into the ID stage register, and redirects on branches resolved in ID. It sits directly upstream of the hazard unit: it consumes `stall_if` and produces the fetch acknowledge that the hazard unit uses as its instruction-side ack input.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr_i`  out  32  instruction memory address; always word-aligned.
- `req_i`  out  1  instruction request; `addr_i` is stable while it is high.
- `rd_i`  in  32  instruction read data; valid only when `req_ack_i` is high.
- `req_ack_i`  in  1  memory acknowledge; pulses high in the cycle `rd_i` is valid.
- `stall_if`  in  1  fetch/ID stall from the hazard unit.
- `branch_taken`  in  1  ID stage redirect request.
- `branch_target`  in  32  redirect address.
- `fetch_ack`  out  1  instruction available this cycle; drives the hazard unit's instruction ack input.
- `instr_id`  out  32  ID stage instruction register.
- `pc_id`  out  32  PC of `instr_id`.
- `fetch_cnt`  out  32  delivered-instruction counter (see Configuration).

## Operation
FSM states:
- IDLE: the reset state.
  - Unconditionally moves to REQ on the first clock edge after `rst` deasserts.
- REQ: `req_i`=1, `addr_i`=`pc_if`.
  - No `req_ack_i`: stay in REQ.
  - `req_ack_i` & ~`stall_if` & ~`branch_taken`: `instr_id`<=`rd_i`, `pc_id`<=`pc_if`, `pc_if`<=`pc_if`+4; stay in REQ.
  - `req_ack_i` & ~`stall_if` & `branch_taken`: `rd_i` is discarded, `instr_id`<=NOP (32'h0000_0013), `pc_id` unchanged, `pc_if`<=`{branch_target[31:2],2'b00}`; stay in REQ.
  - `req_ack_i` & `stall_if`: `rd_i` is captured into the skid buffer; go to HOLD.
- HOLD: `req_i`=0; `pc_if` holds the PC of the buffered word.
  - `stall_if`: stay in HOLD.
  - ~`stall_if` & ~`branch_taken`: `instr_id`<=skid word, `pc_id`<=`pc_if`, `pc_if`+=4; go to REQ.
  - ~`stall_if` & `branch_taken`: the skid word is discarded, `instr_id`<=NOP, `pc_if`<=aligned target; go to REQ.

Signal rules:
- `fetch_ack` = (REQ & `req_ack_i`) | HOLD. Combinational.
- `branch_taken` is ignored while `stall_if`=1. A redirect takes effect only together with a delivery slot.
- `pc_if` arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `branch_target[1:0]` is ignored.

## Timing
- Reset values: `addr_i`=`RESET_VECTOR`, `req_i`=0, `instr_id`=NOP, `pc_id`=0, `fetch_ack`=0, `fetch_cnt`=0, skid buffer empty.
- `req_i` rises in the first cycle after `rst` deasserts.
- Zero-wait memory: one instruction per cycle. `instr_id` updates on the edge that ends the ack cycle, and `addr_i` advances on the same edge.
- The memory may hold `req_ack_i` low for any number of cycles; `addr_i` must stay stable for that whole time.
- After a HOLD, the new request is issued in the cycle after release.
- Asserting `rst` mid-request forces `req_i` low immediately; any later `req_ack_i` is ignored until REQ is re-entered.

## Configuration
Macro: `NF_FU_FETCH_CNT_EN`.
- Defined: `fetch_cnt` increments by 1 on each edge that loads a real instruction into `instr_id`, from either `rd_i` or the skid buffer. NOP insertions do not count. The counter wraps at 2^32 and is reset to 0.
- Undefined: `fetch_cnt` is tied to 0 and no counter flops are built.

## Structure
- Shared package `nf_fu_pkg`:
  - FSM enum `fu_state_t` {IDLE, REQ, HOLD}.
  - `FU_NOP` = 32'h0000_0013.
  - `FU_PC_INC` = 4.
- One sub-module, `nf_fu_skid`: a one-entry 32-bit buffer with a valid bit.
  - Loaded on `req_ack_i` & `stall_if`.
  - Cleared on release or branch.
  - Cleared on `rst`.

## Test plan
- Zero-wait memory, `RESET_VECTOR`=0 → `addr_i` sequence 0,4,8. `instr_id`=mem[0] one cycle after the first ack, with `pc_id`=0. `fetch_cnt`=3 after three deliveries.
- Ack for 0x4 delayed 3 cycles → `req_i` held at 1, `addr_i`=0x4 stable, `fetch_ack`=0 for 3 cycles, `instr_id` unchanged.
- Ack at 0x8 with `stall_if`=1 for 2 cycles:
  - `req_i`=0, `fetch_ack`=1, `instr_id` held.
  - On release: `instr_id`=mem[8], `pc_id`=0x8, `addr_i`=0xC.
- `branch_taken` with target 0x102 on an ack cycle → `instr_id`=0x13, `addr_i`=0x100 next cycle, `fetch_cnt` unchanged.
- `branch_taken` on HOLD release → skid word never appears on `instr_id`, next `addr_i`=aligned target.
- `rst` pulsed while `req_i`=1 with the ack pending → `req_i`=0 immediately, all outputs at reset values, refetch starts from `RESET_VECTOR`.

Source files
------------

// File: rtl/nf_fu_pkg.sv
// Shared types and constants for the nanoFOX instruction fetch unit.
// Optional counter feature is selected by NF_FU_FETCH_CNT_EN (see nf_i_fu_pipe).
package nf_fu_pkg;

    localparam int unsigned FU_XLEN = 32;

    localparam logic [FU_XLEN-1:0] FU_NOP    = 32'h0000_0013;
    localparam logic [FU_XLEN-1:0] FU_PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fu_state_t;

    // Word-align an address by clearing the two byte-offset bits.
    function automatic logic [FU_XLEN-1:0] fu_align(input logic [FU_XLEN-1:0] a);
        return a & ~FU_XLEN'(3);
    endfunction

endpackage

// File: rtl/nf_fu_skid.sv
// One-entry skid buffer holding an instruction word acked while ID was stalled.
module nf_fu_skid
    import nf_fu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [FU_XLEN-1:0] din,
    output logic [FU_XLEN-1:0] data,
    output logic               valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nf_i_fu_pipe.sv
// nanoFOX pipelined instruction fetch: PC, imem handshake, ID register, branch redirect.
// Define NF_FU_FETCH_CNT_EN to build the delivered-instruction counter on fetch_cnt.
module nf_i_fu_pipe
    import nf_fu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addr_i,
    output logic        req_i,
    input  logic [31:0] rd_i,
    input  logic        req_ack_i,
    input  logic        stall_if,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_ack,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] fetch_cnt
);

    fu_state_t          state;
    logic [FU_XLEN-1:0] pc_if;
    logic [FU_XLEN-1:0] skid_data;
    logic               skid_valid;

    logic mem_offer;
    logic hold_offer;
    logic slot;
    logic load_real;
    logic take_branch;
    logic skid_load;

    // A delivery slot is a memory ack or a buffered word, either one only when ID is not stalled.
    assign mem_offer   = (state == REQ) && req_ack_i;
    assign hold_offer  = (state == HOLD) && skid_valid;
    assign slot        = (mem_offer || hold_offer) && !stall_if;
    assign load_real   = slot && !branch_taken;
    assign take_branch = slot && branch_taken;
    assign skid_load   = mem_offer && stall_if;

    assign fetch_ack = mem_offer || hold_offer;
    assign addr_i    = pc_if;

    nf_fu_skid u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (hold_offer && !stall_if),
        .din   (rd_i),
        .data  (skid_data),
        .valid (skid_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_i    <= 1'b0;
            pc_if    <= RESET_VECTOR;
            instr_id <= FU_NOP;
            pc_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_i <= 1'b1;
                end
                REQ: begin
                    if (skid_load) begin
                        state <= HOLD;
                        req_i <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_offer && !stall_if) begin
                        state <= REQ;
                        req_i <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_i <= 1'b0;
                end
            endcase

            if (load_real) begin
                instr_id <= (state == HOLD) ? skid_data : rd_i;
                pc_id    <= pc_if;
                pc_if    <= pc_if + FU_PC_INC;
            end else if (take_branch) begin
                instr_id <= FU_NOP;
                pc_if    <= fu_align(branch_target);
            end
        end
    end

`ifdef NF_FU_FETCH_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_real) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_nf_i_fu_pipe.sv
// Self-checking bench for nf_i_fu_pipe: transaction-level model plus directed literal checks.
module tb_nf_i_fu_pipe;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef NF_FU_FETCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i;
    logic        req_i;
    logic [31:0] rd_i;
    logic        req_ack_i = 1'b0;
    logic        stall_if = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        fetch_ack;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    assign rd_i = memf(addr_i);

    nf_i_fu_pipe #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr_i        (addr_i),
        .req_i         (req_i),
        .rd_i          (rd_i),
        .req_ack_i     (req_ack_i),
        .stall_if      (stall_if),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_ack     (fetch_ack),
        .instr_id      (instr_id),
        .pc_id         (pc_id),
        .fetch_cnt     (fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch unit viewed as transactions: a fetch address, an optional parked word, and the ID register.
    logic        m_active, m_buf_v;
    logic [31:0] m_buf_w, m_pc, m_instr, m_pcid, m_cnt;

    task deliver(input logic [31:0] w);
        if (branch_taken) begin
            m_instr = NOP;
            m_pc    = {branch_target[31:2], 2'b00};
        end else begin
            m_instr = w;
            m_pcid  = m_pc;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_buf_v  = 1'b0;
            m_buf_w  = '0;
            m_pc     = RV;
            m_instr  = NOP;
            m_pcid   = '0;
            m_cnt    = '0;
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (m_buf_v) begin
            if (!stall_if) begin
                m_buf_v = 1'b0;
                deliver(m_buf_w);
            end
        end else if (req_ack_i) begin
            if (stall_if) begin
                m_buf_v = 1'b1;
                m_buf_w = memf(m_pc);
            end else begin
                deliver(memf(m_pc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_addr", addr_i, m_pc);
            chk("m_req", 32'(req_i), 32'(m_active && !m_buf_v));
            chk("m_instr", instr_id, m_instr);
            chk("m_pc_id", pc_id, m_pcid);
            chk("m_cnt", fetch_cnt, CNT_EN ? m_cnt : 32'd0);
            chk("m_fetch_ack", 32'(fetch_ack), 32'(m_active && (m_buf_v || req_ack_i)));
        end
    end

    task automatic drive(input logic ack, input logic stl, input logic br, input logic [31:0] tgt);
        req_ack_i     = ack;
        stall_if      = stl;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [31:0] a, input logic r,
                       input logic [31:0] ins, input logic [31:0] pid);
        chk({tag, "_addr"}, addr_i, a);
        chk({tag, "_req"}, 32'(req_i), 32'(r));
        chk({tag, "_instr"}, instr_id, ins);
        chk({tag, "_pc_id"}, pc_id, pid);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        tick();
        tick();
        lit("reset", RV, 1'b0, NOP, 32'h0);
        chk("reset_ack", 32'(fetch_ack), 32'h0);
        chk("reset_cnt", fetch_cnt, 32'h0);
        rst = 1'b0;

        tick();
        lit("first_req", 32'h0, 1'b1, NOP, 32'h0);

        // zero-wait fetch of 0x0
        drive(1, 0, 0, 0);
        tick();
        lit("fetch0", 32'h4, 1'b1, 32'h1000_0000, 32'h0);

        // ack for 0x4 delayed three cycles
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("wait4", 32'h4, 1'b1, 32'h1000_0000, 32'h0);
            chk("wait4_ack", 32'(fetch_ack), 32'h0);
        end
        drive(1, 0, 0, 0);
        tick();
        lit("fetch4", 32'h8, 1'b1, 32'h1000_0004, 32'h4);

        // ack at 0x8 with ID stalled for two cycles
        drive(1, 1, 0, 0);
        tick();
        lit("hold1", 32'h8, 1'b0, 32'h1000_0004, 32'h4);
        drive(0, 1, 0, 0);
        chk("hold_ack", 32'(fetch_ack), 32'h1);
        tick();
        lit("hold2", 32'h8, 1'b0, 32'h1000_0004, 32'h4);
        drive(0, 0, 0, 0);
        tick();
        lit("release", 32'hC, 1'b1, 32'h1000_0008, 32'h8);
        chk("cnt3", fetch_cnt, CNT_EN ? 32'd3 : 32'd0);

        // branch on an ack cycle, unaligned target
        drive(1, 0, 1, 32'h102);
        tick();
        lit("br_ack", 32'h100, 1'b1, NOP, 32'h8);
        chk("br_cnt", fetch_cnt, CNT_EN ? 32'd3 : 32'd0);
        drive(1, 0, 0, 0);
        tick();
        lit("fetch100", 32'h104, 1'b1, 32'h1000_0100, 32'h100);

        // branch presented during stall is ignored, then taken on release
        drive(1, 1, 1, 32'h200);
        tick();
        lit("br_hold", 32'h104, 1'b0, 32'h1000_0100, 32'h100);
        drive(0, 0, 1, 32'h203);
        tick();
        lit("br_release", 32'h200, 1'b1, NOP, 32'h100);
        chk("br_release_cnt", fetch_cnt, CNT_EN ? 32'd4 : 32'd0);

        // wrap-around of the fetch PC
        drive(1, 0, 1, 32'hFFFF_FFFF);
        tick();
        lit("br_top", 32'hFFFF_FFFC, 1'b1, NOP, 32'h100);
        drive(1, 0, 0, 0);
        tick();
        lit("wrap", 32'h0, 1'b1, 32'h0FFF_FFFC, 32'hFFFF_FFFC);
        chk("wrap_cnt", fetch_cnt, CNT_EN ? 32'd5 : 32'd0);

        // mixed traffic checked against the model only
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom);
            tick();
        end

        // reset while a request is outstanding
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("pre_rst_req", 32'(req_i), 32'h1);
        drive(1, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        lit("mid_rst", RV, 1'b0, NOP, 32'h0);
        chk("mid_rst_ack", 32'(fetch_ack), 32'h0);
        chk("mid_rst_cnt", fetch_cnt, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        lit("refetch_req", RV, 1'b1, NOP, 32'h0);
        tick();
        lit("refetch0", 32'h4, 1'b1, 32'h1000_0000, 32'h0);
        drive(0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
